// File: rtl/sync_fifo_pkg.sv
// Width helpers shared by sync_fifo and its storage array.
package sync_fifo_pkg;

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int fifo_lw(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_pw(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH simple dual-port storage: one write port, one registered read port.
// Only the read register is reset; the array itself is not, so a BRAM macro can replace it.
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = fifo_pw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-address read and write returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy level, almost flags and sticky error flags.
// Define SYNC_FIFO_HWM_EN to add the hwm (high-water mark) output.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    localparam int LW = fifo_lw(DEPTH),
    localparam int PW = fifo_pw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             not_empty,
    output logic             not_full,
    output logic [LW-1:0]    level,
    output logic             almost_full,
    output logic             almost_empty,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
`ifdef SYNC_FIFO_HWM_EN
    ,
    output logic [LW-1:0]    hwm
`endif
);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          rvalid_q, rvalid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          rd_ok;
    logic          wr_ok;

    // Explicit wrap compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign not_empty    = (level_q != '0);
    assign not_full     = (level_q != LW'(DEPTH));
    assign almost_full  = (level_q >= LW'(AFULL_LEVEL));
    assign almost_empty = (level_q <= LW'(AEMPTY_LEVEL));
    assign level        = level_q;
    assign rvalid       = rvalid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok = rd & not_empty;
    assign wr_ok = wr & (not_full | rd_ok);

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        rvalid_d = rd_ok;
        if (wr_ok) begin
            wptr_d = ptr_next(wptr_q);
        end
        if (rd_ok) begin
            rptr_d = ptr_next(rptr_q);
        end
        if (wr_ok && !rd_ok) begin
            level_d = level_q + LW'(1);
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - LW'(1);
        end
        overflow_d  = (overflow_q & ~clr_err) | (wr & ~wr_ok);
        underflow_d = (underflow_q & ~clr_err) | (rd & ~not_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            rvalid_q    <= rvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_ok),
        .waddr(wptr_q),
        .wdata(wdata),
        .re   (rd_ok),
        .raddr(rptr_q),
        .rdata(rdata)
    );

`ifdef SYNC_FIFO_HWM_EN
    logic [LW-1:0] hwm_q, hwm_d;

    // Clearing restarts tracking from the level the FIFO is about to hold.
    always_comb begin
        hwm_d = hwm_q;
        if (clr_err) begin
            hwm_d = level_d;
        end else if (level_d > hwm_q) begin
            hwm_d = level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
        level_q <= LW'(DEPTH));

    a_ptr_level: assert property (@(posedge clk) disable iff (!rst_n)
        ((int'(wptr_q) - int'(rptr_q) + DEPTH) % DEPTH) == (int'(level_q) % DEPTH));

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: DEPTH=4 and DEPTH=5 instances share one directed + random stimulus stream
// and are compared every cycle against a queue-based model. Honours SYNC_FIFO_HWM_EN.
module tb_sync_fifo;

    localparam int LW = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       wr     = 1'b0;
    logic       rd     = 1'b0;
    logic       clrErr = 1'b0;
    logic [7:0] wdata  = 8'h00;

    logic [7:0]    rdata4, rdata5;
    logic          rvalid4, rvalid5;
    logic          notEmpty4, notEmpty5;
    logic          notFull4, notFull5;
    logic [LW-1:0] level4, level5;
    logic          aFull4, aFull5;
    logic          aEmpty4, aEmpty5;
    logic          ovf4, ovf5;
    logic          udf4, udf5;
`ifdef SYNC_FIFO_HWM_EN
    logic [LW-1:0] hwm4, hwm5;
`endif

    int checkCount = 0;
    int failCount  = 0;

    // Model state, index 0 = DEPTH 4, index 1 = DEPTH 5
    int         depthM [2] = '{4, 5};
    int         afullM [2] = '{3, 4};
    localparam int AEMPTY = 1;
    logic [7:0] mq [2][$];
    logic       expRvalid [2] = '{1'b0, 1'b0};
    logic [7:0] expRdata [2]  = '{8'h00, 8'h00};
    logic       expOvf [2]    = '{1'b0, 1'b0};
    logic       expUdf [2]    = '{1'b0, 1'b0};
    int         expHwm [2]    = '{0, 0};

    sync_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo4 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wdata(wdata), .rd(rd),
        .rdata(rdata4), .rvalid(rvalid4), .not_empty(notEmpty4), .not_full(notFull4),
        .level(level4), .almost_full(aFull4), .almost_empty(aEmpty4),
        .clr_err(clrErr), .overflow(ovf4), .underflow(udf4)
`ifdef SYNC_FIFO_HWM_EN
        , .hwm(hwm4)
`endif
    );

    sync_fifo #(.WIDTH(8), .DEPTH(5)) u_fifo5 (
        .clk(clk), .rst_n(rst_n), .wr(wr), .wdata(wdata), .rd(rd),
        .rdata(rdata5), .rvalid(rvalid5), .not_empty(notEmpty5), .not_full(notFull5),
        .level(level5), .almost_full(aFull5), .almost_empty(aEmpty5),
        .clr_err(clrErr), .overflow(ovf5), .underflow(udf5)
`ifdef SYNC_FIFO_HWM_EN
        , .hwm(hwm5)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            expRvalid[k] = 1'b0;
            expRdata[k]  = 8'h00;
            expOvf[k]    = 1'b0;
            expUdf[k]    = 1'b0;
            expHwm[k]    = 0;
        end
    endtask

    task automatic modelStep(input int k);
        int   lvl;
        logic rdOk;
        logic wrOk;
        lvl  = mq[k].size();
        rdOk = rd && (lvl != 0);
        wrOk = wr && ((lvl < depthM[k]) || rdOk);
        expRvalid[k] = rdOk;
        if (rdOk) expRdata[k] = mq[k].pop_front();
        if (wrOk) mq[k].push_back(wdata);
        if (wr && !wrOk)    expOvf[k] = 1'b1;
        else if (clrErr)    expOvf[k] = 1'b0;
        if (rd && lvl == 0) expUdf[k] = 1'b1;
        else if (clrErr)    expUdf[k] = 1'b0;
        if (clrErr || mq[k].size() > expHwm[k]) expHwm[k] = mq[k].size();
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) modelReset();
        else for (int k = 0; k < 2; k++) modelStep(k);
    end

    task automatic checkInst(input int k, input logic [7:0] rdataV, input logic rvalidV,
                             input logic [LW-1:0] levelV, input logic neV, input logic nfV,
                             input logic afV, input logic aeV, input logic ovfV, input logic udfV);
        string tag;
        int    lvl;
        tag = $sformatf("d%0d", depthM[k]);
        lvl = mq[k].size();
        checkOutput({tag, ".rvalid"},   32'(rvalidV), 32'(expRvalid[k]));
        checkOutput({tag, ".rdata"},    32'(rdataV),  32'(expRdata[k]));
        checkOutput({tag, ".level"},    32'(levelV),  lvl);
        checkOutput({tag, ".notEmpty"}, 32'(neV),     32'(lvl != 0));
        checkOutput({tag, ".notFull"},  32'(nfV),     32'(lvl != depthM[k]));
        checkOutput({tag, ".aFull"},    32'(afV),     32'(lvl >= afullM[k]));
        checkOutput({tag, ".aEmpty"},   32'(aeV),     32'(lvl <= AEMPTY));
        checkOutput({tag, ".overflow"}, 32'(ovfV),    32'(expOvf[k]));
        checkOutput({tag, ".underflow"},32'(udfV),    32'(expUdf[k]));
    endtask

    // Every cycle out of reset, both instances against the model
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            checkInst(0, rdata4, rvalid4, level4, notEmpty4, notFull4, aFull4, aEmpty4, ovf4, udf4);
            checkInst(1, rdata5, rvalid5, level5, notEmpty5, notFull5, aFull5, aEmpty5, ovf5, udf5);
`ifdef SYNC_FIFO_HWM_EN
            checkOutput("d4.hwm", 32'(hwm4), expHwm[0]);
            checkOutput("d5.hwm", 32'(hwm5), expHwm[1]);
`endif
        end
    end

    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr     = w;
        rd     = r;
        wdata  = d;
        clrErr = c;
        @(posedge clk);
        #2;
    endtask

    task automatic checkResetValues(input string when);
        checkOutput({when, ".level"},    32'(level4),    0);
        checkOutput({when, ".rdata"},    32'(rdata4),    0);
        checkOutput({when, ".rvalid"},   32'(rvalid4),   0);
        checkOutput({when, ".notEmpty"}, 32'(notEmpty4), 0);
        checkOutput({when, ".notFull"},  32'(notFull4),  1);
        checkOutput({when, ".aEmpty"},   32'(aEmpty4),   1);
        checkOutput({when, ".aFull"},    32'(aFull4),    0);
        checkOutput({when, ".overflow"}, 32'(ovf4),      0);
        checkOutput({when, ".underflow"},32'(udf4),      0);
        checkOutput({when, ".d5level"},  32'(level5),    0);
        checkOutput({when, ".d5rdata"},  32'(rdata5),    0);
    endtask

    initial begin
        int wp;
        #12;
        checkResetValues("reset");
        rst_n = 1'b1;

        // Three writes on consecutive cycles
        applyStimulus(1'b1, 1'b0, 8'haa, 1'b0);
        checkOutput("wr1.level", 32'(level4), 1);
        checkOutput("wr1.notEmpty", 32'(notEmpty4), 1);
        applyStimulus(1'b1, 1'b0, 8'hbb, 1'b0);
        checkOutput("wr2.level", 32'(level4), 2);
        applyStimulus(1'b1, 1'b0, 8'hcc, 1'b0);
        checkOutput("wr3.level", 32'(level4), 3);
        checkOutput("wr3.aFull", 32'(aFull4), 1);
        checkOutput("wr3.d5aFull", 32'(aFull5), 0);
        checkOutput("wr3.overflow", 32'(ovf4), 0);

        // Four reads: three words then an underflow
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("rd1.rvalid", 32'(rvalid4), 1);
        checkOutput("rd1.rdata", 32'(rdata4), 32'haa);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("rd2.rdata", 32'(rdata4), 32'hbb);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("rd3.rdata", 32'(rdata4), 32'hcc);
        checkOutput("rd3.underflow", 32'(udf4), 0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("rd4.rvalid", 32'(rvalid4), 0);
        checkOutput("rd4.underflow", 32'(udf4), 1);
        checkOutput("rd4.level", 32'(level4), 0);
        checkOutput("rd4.aEmpty", 32'(aEmpty4), 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("clr.underflow", 32'(udf4), 0);

        // Fill, overflow, then read+write while full
        applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h22, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h44, 1'b0);
        checkOutput("fill.notFull", 32'(notFull4), 0);
        applyStimulus(1'b1, 1'b0, 8'hee, 1'b0);
        checkOutput("ovf.overflow", 32'(ovf4), 1);
        checkOutput("ovf.level", 32'(level4), 4);
        checkOutput("ovf.d5level", 32'(level5), 5);
        checkOutput("ovf.d5overflow", 32'(ovf5), 0);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
        checkOutput("rdwr.rdata", 32'(rdata4), 32'h11);
        checkOutput("rdwr.level", 32'(level4), 4);
`ifdef SYNC_FIFO_HWM_EN
        checkOutput("hwm.before", 32'(hwm4), 4);
`endif

        // Clear racing a new overflow, then clear alone while reading
        applyStimulus(1'b1, 1'b0, 8'h66, 1'b1);
        checkOutput("clrset.overflow", 32'(ovf4), 1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        checkOutput("clronly.overflow", 32'(ovf4), 0);
        checkOutput("clronly.rdata", 32'(rdata4), 32'h22);
        checkOutput("clronly.level", 32'(level4), 3);
`ifdef SYNC_FIFO_HWM_EN
        checkOutput("hwm.after", 32'(hwm4), 3);
`endif

        // Random traffic in alternating write-heavy / read-heavy phases
        for (int i = 0; i < 600; i++) begin
            wp = ((i / 40) % 2 == 0) ? 70 : 30;
            applyStimulus($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                          8'($urandom), $urandom_range(0, 99) < 3);
        end

        // Drain, build level 3 with an overflow pending, then reset mid-cycle
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'ha1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'ha2, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'ha3, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'ha4, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'ha5, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("pre.level", 32'(level4), 3);
        checkOutput("pre.rvalid", 32'(rvalid4), 1);
        checkOutput("pre.overflow", 32'(ovf4), 1);
        wr = 1'b0;
        rd = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        #10;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("post.underflow", 32'(udf4), 1);
        checkOutput("post.rvalid", 32'(rvalid4), 0);
        checkOutput("post.rdata", 32'(rdata4), 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
